// File: rtl/issue_age_alloc.sv
// Reservation-station slot and age-tag allocator: lowest-free-entry assignment per
// dispatch lane, wrapping age tags with an epoch bit, and frees on the issue grant.
module issue_age_alloc #(
    parameter int ENTRY_NUM      = 16,
    parameter int AGE_WIDTH      = 6,
    parameter int DISPATCH_WIDTH = 3
) (
    input  logic                                                clock,
    input  logic                                                reset,
    input  logic [DISPATCH_WIDTH-1:0]                           dispatch_valid,
    output logic                                                dispatch_ready,
    output logic [DISPATCH_WIDTH-1:0][$clog2(ENTRY_NUM)-1:0]    alloc_idx,
    input  logic [ENTRY_NUM-1:0]                                issue_gnt,
    input  logic                                                flush,
    output logic [ENTRY_NUM-1:0]                                entry_valid,
    output logic [ENTRY_NUM-1:0][AGE_WIDTH-1:0]                 entry_age,
    output logic [ENTRY_NUM-1:0]                                entry_pos,
    output logic [$clog2(ENTRY_NUM):0]                          free_cnt
);
    localparam int IDX_W = $clog2(ENTRY_NUM);
    localparam int CNT_W = IDX_W + 1;

    logic [CNT_W-1:0]                           free_cnt_reg, free_cnt_next;
    logic [AGE_WIDTH-1:0]                       age_cnt_reg, age_cnt_next;
    logic                                       cur_pos_reg, cur_pos_next;
    logic [AGE_WIDTH:0]                         adv_sum;
    logic [DISPATCH_WIDTH-1:0][CNT_W-1:0]       lane_rank;
    logic [DISPATCH_WIDTH-1:0][AGE_WIDTH:0]     lane_sum;
    logic [CNT_W-1:0]                           req_cnt, acc_cnt, freed_cnt, free_seen;
    logic                                       accept;
    logic [ENTRY_NUM-1:0]                       wr_en;
    logic [ENTRY_NUM-1:0][AGE_WIDTH-1:0]        wr_age;
    logic [ENTRY_NUM-1:0]                       wr_pos;

    assign dispatch_ready = (free_cnt_reg >= CNT_W'(DISPATCH_WIDTH));
    assign free_cnt       = free_cnt_reg;
    assign accept         = dispatch_ready && !flush && (|dispatch_valid);
    assign acc_cnt        = accept ? req_cnt : '0;

    // Rank of each lane among the asserted lanes (lane 0 oldest).
    always_comb begin
        req_cnt = '0;
        for (int d = 0; d < DISPATCH_WIDTH; d++) begin
            lane_rank[d] = req_cnt;
            if (dispatch_valid[d]) req_cnt = req_cnt + CNT_W'(1);
        end
    end

    // The lane of rank j picks the j-th lowest registered-invalid entry.
    always_comb begin
        free_seen = '0;
        alloc_idx = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (!entry_valid[i]) begin
                for (int d = 0; d < DISPATCH_WIDTH; d++) begin
                    if (dispatch_valid[d] && (lane_rank[d] == free_seen))
                        alloc_idx[d] = IDX_W'(i);
                end
                free_seen = free_seen + CNT_W'(1);
            end
        end
    end

    // Carry out of the age add marks a lane that crossed into the next epoch.
    always_comb begin
        for (int d = 0; d < DISPATCH_WIDTH; d++)
            lane_sum[d] = {1'b0, age_cnt_reg} + (AGE_WIDTH+1)'(lane_rank[d]);
    end

    always_comb begin
        wr_en  = '0;
        wr_age = '0;
        wr_pos = '0;
        for (int d = 0; d < DISPATCH_WIDTH; d++) begin
            if (accept && dispatch_valid[d]) begin
                wr_en[alloc_idx[d]]  = 1'b1;
                wr_age[alloc_idx[d]] = lane_sum[d][AGE_WIDTH-1:0];
                wr_pos[alloc_idx[d]] = cur_pos_reg ^ lane_sum[d][AGE_WIDTH];
            end
        end
    end

    always_comb begin
        freed_cnt = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (issue_gnt[i] && entry_valid[i]) freed_cnt = freed_cnt + CNT_W'(1);
        end
    end

    assign adv_sum       = {1'b0, age_cnt_reg} + (AGE_WIDTH+1)'(acc_cnt);
    assign age_cnt_next  = adv_sum[AGE_WIDTH-1:0];
    assign cur_pos_next  = cur_pos_reg ^ adv_sum[AGE_WIDTH];
    assign free_cnt_next = free_cnt_reg + freed_cnt - acc_cnt;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            free_cnt_reg <= CNT_W'(ENTRY_NUM);
            age_cnt_reg  <= '0;
            cur_pos_reg  <= 1'b0;
        end else begin
            free_cnt_reg <= free_cnt_next;
            age_cnt_reg  <= age_cnt_next;
            cur_pos_reg  <= cur_pos_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENTRY_NUM; gi++) begin : g_entry
            logic                 valid_reg;
            logic [AGE_WIDTH-1:0] age_reg;
            logic                 pos_reg;

            // A freed or flushed entry keeps its stale tag; only reset zeroes it.
            always_ff @(posedge clock) begin
                if (reset) begin
                    valid_reg <= 1'b0;
                    age_reg   <= '0;
                    pos_reg   <= 1'b0;
                end else if (flush) begin
                    valid_reg <= 1'b0;
                end else if (wr_en[gi]) begin
                    valid_reg <= 1'b1;
                    age_reg   <= wr_age[gi];
                    pos_reg   <= wr_pos[gi];
                end else if (issue_gnt[gi]) begin
                    valid_reg <= 1'b0;
                end
            end

            assign entry_valid[gi] = valid_reg;
            assign entry_age[gi]   = age_reg;
            assign entry_pos[gi]   = pos_reg;
        end
    endgenerate

endmodule

// File: doc/issue_age_alloc.md
# issue_age_alloc

Slot and age-tag allocator for a reservation station in the 3-way out-of-order core. It accepts up to DISPATCH_WIDTH instructions per cycle in program order. Each accepted instruction gets the lowest free entry plus a monotonically increasing age tag with an epoch (wrap) bit. It presents per-entry valid/age/pos state that feeds the oldest-first issue selector, and it frees entries on that selector's one-hot grant.

## Interface
- ENTRY_NUM, 16, reservation-station entries; must be 32/16/8/4; requires ENTRY_NUM <= 2**AGE_WIDTH
- AGE_WIDTH, 6, age tag width
- DISPATCH_WIDTH, 3, dispatch lanes; lane 0 is oldest
- One clock; reset is synchronous and active-high.
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- dispatch_valid  in  DISPATCH_WIDTH  per-lane allocation request
- dispatch_ready  out  1  high when free_cnt >= DISPATCH_WIDTH; derived only from registered state
- alloc_idx  out  DISPATCH_WIDTH x $clog2(ENTRY_NUM)  entry assigned to each lane, combinational, same cycle
- issue_gnt  in  ENTRY_NUM  one-hot grant from selector; frees that entry
- flush  in  1  squash: invalidate all entries, restart age counter
- entry_valid  out  ENTRY_NUM  registered per-entry valid
- entry_age  out  ENTRY_NUM x AGE_WIDTH  registered age tag (selector data)
- entry_pos  out  ENTRY_NUM  registered epoch bit (selector pos)
- free_cnt  out  $clog2(ENTRY_NUM)+1  registered count of invalid entries

## Operation
- State:
  - entry_valid/entry_age/entry_pos arrays
  - age_cnt (AGE_WIDTH) and cur_pos (1 bit): the tag for the next accepted lane
  - free_cnt
- Accept: dispatch is taken only when dispatch_ready && !flush. The whole valid pattern is accepted together, all-or-nothing.
- If dispatch_valid is nonzero while dispatch_ready=0, the requests are ignored and state is unchanged.
- Slot assignment:
  - Valid lanes may be non-contiguous.
  - The j-th asserted lane, counting from lane 0, takes the j-th lowest-index entry whose entry_valid=0.
  - alloc_idx of a deasserted lane is 0.
- Age assignment:
  - The j-th asserted lane receives tag (age_cnt + j) mod 2**AGE_WIDTH.
  - Its pos is cur_pos, inverted if age_cnt + j overflowed.
  - age_cnt then advances by popcount(accepted lanes). cur_pos toggles on each overflow past 2**AGE_WIDTH-1.
- Ordering contract with the selector:
  - Equal pos: the smaller age is older.
  - Differing pos: the larger age is older.
  - ENTRY_NUM <= 2**AGE_WIDTH guarantees at most two live epochs.
- Free:
  - Any entry with issue_gnt[i]=1 and entry_valid[i]=1 clears its valid bit at the edge.
  - A grant to an invalid entry is ignored.
  - A grant with more than one bit set frees every flagged valid entry; this is not an error.
- free_cnt(next) = free_cnt + freed − accepted.
- A same-cycle free does not make that entry allocatable in the same cycle; allocation sees only registered valids.
- Flush: clears all entry_valid, age_cnt=0, cur_pos=0, free_cnt=ENTRY_NUM. Same-cycle dispatch and issue_gnt are dropped; flush has priority.
- Reset: same as flush.
  - All outputs registered to 0, except free_cnt=ENTRY_NUM and dispatch_ready=1.
  - entry_age and entry_pos are 0 for every entry.
- Freed entries retain their stale age/pos; consumers qualify them with entry_valid.

## Timing
- Allocation latency: 1 cycle. Entry state is written at the accepting edge and visible to the selector the following cycle.
- Free latency: 1 cycle from issue_gnt to entry_valid=0 and the free_cnt update.
- dispatch_ready has no combinational path from dispatch_valid, issue_gnt or flush.
- alloc_idx is combinational from entry_valid and dispatch_valid only.
- Reset or flush mid-stream takes effect at the next edge. All in-flight allocations are lost; the first dispatch after it gets entries 0.. and ages 0...

## Test plan
- Reset, then dispatch_valid=3'b111 → alloc_idx 0/1/2; next cycle entry_valid=0x0007, ages 0/1/2, pos 0, free_cnt=13.
- Entries 0–2 valid, dispatch_valid=3'b101 → lanes 0/2 get entries 3/4 with ages 3/4; lane 1 alloc_idx=0; free_cnt=11.
- age_cnt=62, cur_pos=0, dispatch 3'b111 → ages 62/63/0 with pos 0/0/1; next age_cnt=1, cur_pos=1.
- 14 entries valid: dispatch_ready=0, dispatch_valid=3'b111 is ignored. Same cycle issue_gnt=0x0001 → next cycle free_cnt=3, ready=1, and entry 0 is allocatable.
- Same cycle dispatch 3'b111 and issue_gnt=entry 5 with 10 valid → entry 5 is not reused that cycle; free_cnt 6→4.
- flush together with dispatch 3'b111 and a grant → next cycle all invalid, free_cnt=16; the following dispatch gets entries 0–2, ages 0–2, pos 0.
